// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional per-byte status-poll timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] BAUD_PRESCALER = 32'd10,
  parameter logic [31:0] CTRL_VALUE     = 32'h00000002,
  parameter logic [15:0] TIMEOUT_POLLS  = 16'd1000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_select,
  output logic [3:0]                 uart_wstrb,
  output logic [4:0]                 uart_addr,
  output logic [31:0]                uart_wdata,
  input  logic                       uart_ready,
  input  logic [31:0]                uart_rdata,
  output logic                       init_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_BAUD   = 5'h04;
  localparam logic [4:0] A_STATUS = 5'h0C;
  localparam logic [4:0] A_TXD    = 5'h10;

  typedef enum logic [2:0] {INIT_BAUD, INIT_CTRL, IDLE, POLL, WRITE} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     rr, rr_n, pick, idx, grant_id_n;
  logic              pick_vld;
  logic [NUM_REQ-1:0] pick_oh, ready_n;
  logic [7:0]        pick_byte, byte_q, byte_n;
  logic              sel_n, done_n, xfer_done, tx_wr;
  logic [3:0]        wstrb_n;
  logic [4:0]        addr_n, tx_addr;
  logic [31:0]       wdata_n, tx_wdata;
  logic              busy;
  logic              unused_rdata;

  assign busy         = uart_rdata[0];
  assign unused_rdata = ^uart_rdata[31:1];

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] poll_cnt, poll_cnt_n;
  logic        terr_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_POLLS;
  assign timeout_err    = 1'b0;
`endif

  // First valid requester at or after rr; descending scan so the smallest offset wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    pick_oh   = '0;
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_byte  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = uart_select;
    wstrb_n    = uart_wstrb;
    addr_n     = uart_addr;
    wdata_n    = uart_wdata;
    ready_n    = '0;
    done_n     = init_done;
    grant_id_n = grant_id;
    rr_n       = rr;
    byte_n     = byte_q;
    tx_addr    = '0;
    tx_wdata   = '0;
    tx_wr      = 1'b0;
    xfer_done  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    poll_cnt_n = poll_cnt;
    terr_n     = 1'b0;
`endif
    case (state)
      INIT_BAUD: begin tx_addr = A_BAUD; tx_wdata = BAUD_PRESCALER; tx_wr = 1'b1; end
      INIT_CTRL: begin tx_addr = A_CTRL; tx_wdata = CTRL_VALUE;     tx_wr = 1'b1; end
      POLL:      tx_addr = A_STATUS;
      WRITE:     begin tx_addr = A_TXD; tx_wdata = {24'd0, byte_q}; tx_wr = 1'b1; end
      default: ;
    endcase
    // Every non-idle state owns exactly one bus transaction; a dropped select
    // always spends a cycle low before the next issue, giving the idle gap.
    if (state != IDLE) begin
      if (!uart_select) begin
        sel_n   = 1'b1;
        addr_n  = tx_addr;
        wdata_n = tx_wdata;
        wstrb_n = {4{tx_wr}};
      end else if (uart_ready) begin
        sel_n     = 1'b0;
        addr_n    = '0;
        wdata_n   = '0;
        wstrb_n   = '0;
        xfer_done = 1'b1;
      end
    end
    case (state)
      INIT_BAUD: if (xfer_done) state_n = INIT_CTRL;
      INIT_CTRL: if (xfer_done) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      IDLE: if (init_done && pick_vld) begin
        grant_id_n = pick;
        byte_n     = pick_byte;
        ready_n    = pick_oh;
        rr_n       = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + IW'(1);
        state_n    = POLL;
`ifdef UART_ARB_TIMEOUT_EN
        poll_cnt_n = '0;
`endif
      end
      POLL: if (xfer_done) begin
`ifdef UART_ARB_TIMEOUT_EN
        poll_cnt_n = poll_cnt + 16'd1;
        if (!busy) state_n = WRITE;
        else if (poll_cnt_n >= TIMEOUT_POLLS) begin
          state_n = IDLE;
          terr_n  = 1'b1;
        end
`else
        if (!busy) state_n = WRITE;
`endif
      end
      WRITE:   if (xfer_done) state_n = IDLE;
      default: state_n = INIT_BAUD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT_BAUD;
      uart_select <= 1'b0;
      uart_wstrb  <= '0;
      uart_addr   <= '0;
      uart_wdata  <= '0;
      req_ready   <= '0;
      init_done   <= 1'b0;
      grant_id    <= '0;
      rr          <= '0;
      byte_q      <= '0;
    end else begin
      state       <= state_n;
      uart_select <= sel_n;
      uart_wstrb  <= wstrb_n;
      uart_addr   <= addr_n;
      uart_wdata  <= wdata_n;
      req_ready   <= ready_n;
      init_done   <= done_n;
      grant_id    <= grant_id_n;
      rr          <= rr_n;
      byte_q      <= byte_n;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      poll_cnt    <= poll_cnt_n;
      timeout_err <= terr_n;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART register slave.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [8*N-1:0]  req_data = '0;
  logic [N-1:0]    req_ready;
  logic            uart_select;
  logic [3:0]      uart_wstrb;
  logic [4:0]      uart_addr;
  logic [31:0]     uart_wdata;
  logic            uart_ready = 1'b0;
  logic [31:0]     uart_rdata = '0;
  logic            init_done;
  logic [IW-1:0]   grant_id;
  logic            timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BAUD_PRESCALER(32'd10), .CTRL_VALUE(32'h2),
                    .TIMEOUT_POLLS(16'd4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_select(uart_select), .uart_wstrb(uart_wstrb),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_ready(uart_ready),
    .uart_rdata(uart_rdata), .init_done(init_done), .grant_id(grant_id),
    .timeout_err(timeout_err));

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model and bus/handshake monitor state
  int lat = 1, wcnt = 0, busy_cnt = 0, proto_err = 0, early = 0, init_wr = 0, terr_cnt = 0;
  logic [4:0]    log_addr[$];
  logic [31:0]   log_wd[$];
  logic [3:0]    log_ws[$];
  logic [7:0]    tx_q[$];
  logic [N-1:0]  rdy_q[$];
  logic [IW-1:0] gid_q[$];
  logic          in_txn = 1'b0, prev_rdy = 1'b0;
  logic [40:0]   cap;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      uart_ready = 1'b0; wcnt = 0; in_txn = 1'b0; prev_rdy = 1'b0; init_wr = 0;
    end else begin
      if (uart_ready && uart_select) proto_err++;
      if (uart_select) begin
        if (!in_txn) begin cap = {uart_addr, uart_wstrb, uart_wdata}; in_txn = 1'b1; end
        else if ({uart_addr, uart_wstrb, uart_wdata} !== cap) proto_err++;
      end else in_txn = 1'b0;
      if (|req_ready) begin
        rdy_q.push_back(req_ready); gid_q.push_back(grant_id);
        if (prev_rdy) proto_err++;
        if (!init_done) early++;
      end
      prev_rdy = |req_ready;
      if (init_done && init_wr < 2) early++;
      if (timeout_err) terr_cnt++;
      if (uart_ready) uart_ready = 1'b0;
      else if (uart_select) begin
        wcnt++;
        if (wcnt >= lat) begin
          wcnt = 0; uart_ready = 1'b1; init_wr++;
          log_addr.push_back(uart_addr); log_wd.push_back(uart_wdata); log_ws.push_back(uart_wstrb);
          uart_rdata = {31'h12345678, 1'b0};
          if (uart_addr == 5'h0C && busy_cnt > 0) begin uart_rdata[0] = 1'b1; busy_cnt--; end
          if (uart_addr == 5'h10 && uart_wstrb == 4'hF) tx_q.push_back(uart_wdata[7:0]);
        end
      end
    end
  end

  task automatic tick; @(posedge clk); #2; endtask

  function automatic int qsize(input int w);
    case (w)
      0: return log_addr.size();
      1: return tx_q.size();
      default: return gid_q.size();
    endcase
  endfunction

  task automatic wait_sz(input int w, input int n, input string tag);
    int c = 0;
    while (qsize(w) < n && c < 3000) begin tick; c++; end
    check({tag, "_bound"}, 32'(c < 3000), 32'd1);
  endtask

  function automatic int count_addr(input logic [4:0] a);
    int n = 0;
    foreach (log_addr[i]) if (log_addr[i] == a) n++;
    return n;
  endfunction

  task automatic clear_logs;
    log_addr.delete(); log_wd.delete(); log_ws.delete(); tx_q.delete(); rdy_q.delete(); gid_q.delete();
  endtask

  logic [7:0]    exp_tx [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
  logic [IW-1:0] exp_g  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) tick;
    check("rst_select", uart_select, 0);
    check("rst_wstrb", uart_wstrb, 0);
    check("rst_addr", uart_addr, 0);
    check("rst_wdata", uart_wdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Configuration sequence
    reset_n = 1'b1;
    wait_sz(0, 2, "init");
    tick;
    check("init_done_high", init_done, 1);
    check("init0_addr", log_addr[0], 32'h04);
    check("init0_data", log_wd[0], 32'd10);
    check("init0_wstrb", log_ws[0], 32'hF);
    check("init1_addr", log_addr[1], 32'h00);
    check("init1_data", log_wd[1], 32'h2);

    // All four requesters continuously valid
    req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_valid = 4'b1111;
    wait_sz(2, 5, "rr_grants");
    req_valid = '0;
    wait_sz(1, 5, "rr_tx");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_tx%0d", i), tx_q[i], exp_tx[i]);
      check($sformatf("rr_gid%0d", i), gid_q[i], exp_g[i]);
      check($sformatf("rr_rdy%0d", i), rdy_q[i], 32'(1) << exp_g[i]);
    end
    check("rr_poll_addr", log_addr[2], 32'h0C);
    check("rr_poll_wstrb", log_ws[2], 32'h0);
    check("rr_txn_count", log_addr.size(), 12);

    // Single requester, busy status, byte latched at grant
    clear_logs; busy_cnt = 2; lat = 3;
    req_data[7:0] = 8'h61; req_valid = 4'b0001;
    wait_sz(2, 1, "r0_grant");
    req_data[7:0] = 8'hFF; req_valid = '0;
    wait_sz(1, 1, "r0_tx");
    check("r0_rdy", rdy_q[0], 32'b0001);
    check("r0_tx", tx_q[0], 32'h61);
    check("r0_polls", count_addr(5'h0C), 3);
    lat = 1;

    // Rotation: 2, then 1, then 3 and 0 together (pointer at 2)
    clear_logs;
    req_data = {8'h34, 8'h33, 8'h32, 8'h31};
    req_valid = 4'b0100; wait_sz(2, 1, "r2_grant"); req_valid = '0; wait_sz(1, 1, "r2_tx");
    req_valid = 4'b0010; wait_sz(2, 2, "r1_grant"); req_valid = '0; wait_sz(1, 2, "r1_tx");
    req_valid = 4'b1001; wait_sz(2, 3, "r3_grant"); req_valid[3] = 1'b0;
    wait_sz(2, 4, "r30_grant"); req_valid = '0; wait_sz(1, 4, "r30_tx");
    check("wrap_gid0", gid_q[0], 2);
    check("wrap_gid1", gid_q[1], 1);
    check("wrap_gid2", gid_q[2], 3);
    check("wrap_gid3", gid_q[3], 0);
    check("wrap_tx1", tx_q[1], 32'h32);
    check("wrap_tx3", tx_q[3], 32'h31);

    // Reset asserted while a status read is outstanding
    busy_cnt = 1000; lat = 4;
    req_data[7:0] = 8'h5A; req_valid = 4'b0001;
    c = 0;
    while (!(uart_select && uart_addr == 5'h0C) && c < 200) begin tick; c++; end
    check("poll_seen_bound", 32'(c < 200), 1);
    reset_n = 1'b0;
    #1;
    check("async_select_drop", uart_select, 0);
    check("async_init_done", init_done, 0);
    tick;
    busy_cnt = 0; lat = 1; clear_logs;
    reset_n = 1'b1;
    wait_sz(0, 2, "reinit");
    check("reinit0_addr", log_addr[0], 32'h04);
    check("reinit0_data", log_wd[0], 32'd10);
    check("reinit1_addr", log_addr[1], 32'h00);
    wait_sz(2, 1, "post_rst_grant");
    req_valid = '0;
    wait_sz(1, 1, "post_rst_tx");
    check("post_rst_tx", tx_q[0], 32'h5A);

`ifdef UART_ARB_TIMEOUT_EN
    clear_logs; busy_cnt = 1000; terr_cnt = 0;
    req_data[7:0] = 8'h77; req_valid = 4'b0001;
    wait_sz(2, 1, "to_grant"); req_valid = '0;
    c = 0;
    while (terr_cnt == 0 && c < 200) begin tick; c++; end
    repeat (5) tick;
    check("to_polls", count_addr(5'h0C), 4);
    check("to_no_write", tx_q.size(), 0);
    check("to_pulses", terr_cnt, 1);
    busy_cnt = 0;
    req_data[15:8] = 8'h78; req_valid = 4'b0010;
    wait_sz(2, 2, "to_next_grant"); req_valid = '0;
    wait_sz(1, 1, "to_next_tx");
    check("to_next_tx", tx_q[0], 32'h78);
`endif

    check("bus_protocol_errors", proto_err, 0);
    check("early_accept_or_done", early, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
